datamem_pipe: RTL and testbench
===============================

Name: datamem_pipe

Overview:
- Parametrised little-endian, byte-addressed data memory for the load/store unit of the out-of-order core.
- Independent store port (write on clock edge) and load port (valid/ready request, one-cycle registered response with backpressure).
- Supports 1/2/4/8-byte accesses with sign/zero extension.
- Misaligned or out-of-range accesses are flagged as errors, never silently realigned.

Parameters:
ADDR_W, 64, width of ld_addr/st_addr
DATA_W, 64, data width in bits; legal values 32 or 64
DEPTH_BYTES, 1024, storage size in bytes; power of two, > DATA_W/8

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
ld_valid  input  1  load request valid
ld_ready  output  1  load request accepted when ld_valid && ld_ready
ld_addr  input  ADDR_W  load byte address
ld_size  input  2  log2 of access bytes: 0=1B, 1=2B, 2=4B, 3=8B
ld_signed  input  1  1 = sign-extend result to DATA_W; 0 = zero-extend
rsp_valid  output  1  load response valid
rsp_ready  input  1  consumer accepts the response
rsp_data  output  DATA_W  extended load data
rsp_err  output  1  load was misaligned or out of range
st_valid  input  1  store valid; always accepted, no backpressure
st_addr  input  ADDR_W  store byte address
st_size  input  2  same encoding as ld_size
st_data  input  DATA_W  store data; low 2^st_size bytes are used
st_err  output  1  one-cycle pulse after an illegal store

Behaviour:
- Reset values while rst_n is low:
  - rsp_valid=0, rsp_data=0, rsp_err=0, st_err=0, ld_ready=0.
  - Stores are ignored.
  - Storage is not cleared; unwritten bytes read as X.
- Reset asserted mid-operation drops any pending response. After rst_n rises, ld_ready=1 on the next cycle.
- Handshake:
  - ld_ready = !rsp_valid || rsp_ready (combinational; no dependence on ld_valid).
  - An accepted load sets rsp_valid=1 on the next edge. Latency is exactly 1 cycle; throughput is 1 load per cycle.
  - While rsp_valid && !rsp_ready, rsp_data and rsp_err hold stable and no new load is accepted.
  - When rsp_ready=1 and no new load is accepted, rsp_valid clears.
- Legality, for a request of N = 2^size bytes at address A:
  - A is legal iff A mod N == 0, A + N <= DEPTH_BYTES, and all bits of A at and above log2(DEPTH_BYTES) are zero.
  - If DATA_W=32, size=3 is always illegal.
- Load data:
  - Bytes mem[A .. A+N-1] are placed at rsp_data[8N-1:0], little-endian.
  - Upper bits are filled with bit 8N-1 when ld_signed=1, else with 0.
  - Size equal to DATA_W/8 ignores ld_signed.
- Illegal load: response still returned with normal latency and handshake, with rsp_err=1 and rsp_data=0.
- Store:
  - A legal store writes st_data bytes 0..N-1 to mem[A..A+N-1] on the edge where st_valid=1.
  - An illegal store writes nothing, and st_err=1 for exactly the following cycle.
- Simultaneous load accept and store in the same cycle:
  - Non-overlapping bytes: both proceed independently.
  - Overlapping bytes, without forwarding: the load returns the pre-store values (read-before-write).
- Store on the same edge as a held (stalled) response: the held rsp_data is not altered.

Optional Feature:
- Macro DATAMEM_STORE_FWD_EN.
- Defined: on a same-cycle overlap between an accepted legal load and a legal store, each overlapping byte of the load result takes the new st_data byte (per-byte merge, before extension). Non-overlapping bytes come from storage.
- Undefined: read-before-write as in Behaviour; no forwarding logic is generated.

Test Plan:
- Store 8B 0x8877665544332211 @0x10, then load 8B @0x10 the next cycle -> rsp_valid one cycle after accept, rsp_data=0x8877665544332211, rsp_err=0.
- Load 1B @0x17 with ld_signed=1 -> 0xFFFFFFFFFFFFFF88. Load 2B @0x16 with ld_signed=0 -> 0x0000000000008877.
- Hold rsp_ready=0 for 3 cycles after a load -> ld_ready=0 and rsp_data stable throughout. Raise rsp_ready with ld_valid=1 -> back-to-back responses with no bubble.
- Load 4B @0x12 -> rsp_err=1, rsp_data=0. Store 8B @0x3FC (DEPTH 1024) -> st_err pulses 1 cycle, memory unchanged. Load 4B @0x3FC -> rsp_err=0.
- Same cycle: store 4B 0xDEADBEEF @0x20 and load 8B @0x20, with memory previously 0 -> without macro rsp_data=0; with DATAMEM_STORE_FWD_EN rsp_data=0x00000000DEADBEEF.
- Accept a load, then drive rst_n=0 asynchronously before the response is consumed -> rsp_valid drops immediately. After release, ld_ready=1 and previously stored data is intact.

Source files
------------

// File: rtl/datamem_pipe_if.sv
// datamem_pipe_if: load request, load response and store channels of the
// data memory. The master modport is the load/store unit side, the slave
// modport is the memory side.
interface datamem_pipe_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);

   // Load request channel
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [1:0]        ld_size;
   logic              ld_signed;

   // Load response channel
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   // Store channel
   logic              st_valid;
   logic [ADDR_W-1:0] st_addr;
   logic [1:0]        st_size;
   logic [DATA_W-1:0] st_data;
   logic              st_err;

   modport master (
      output ld_valid, ld_addr, ld_size, ld_signed, rsp_ready,
             st_valid, st_addr, st_size, st_data,
      input  ld_ready, rsp_valid, rsp_data, rsp_err, st_err
   );

   modport slave (
      input  ld_valid, ld_addr, ld_size, ld_signed, rsp_ready,
             st_valid, st_addr, st_size, st_data,
      output ld_ready, rsp_valid, rsp_data, rsp_err, st_err
   );

endinterface

// File: rtl/datamem_pipe.sv
// datamem_pipe: little-endian, byte-addressed data memory for the load/store
// unit. Independent store port (writes on the clock edge) and a valid/ready
// load port with a single registered response stage that holds under
// backpressure. Accesses of 1/2/4/8 bytes; misaligned or out-of-range
// accesses are reported as errors and never touch storage.
//
// Optional feature: define DATAMEM_STORE_FWD_EN to merge the bytes of a
// same-cycle legal store into an overlapping legal load. Without it an
// overlapping load sees the pre-store storage contents (read-before-write).
module datamem_pipe #(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int DEPTH_BYTES = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   datamem_pipe_if.slave bus
);

   localparam int NB = DATA_W / 8;
   localparam int AW = $clog2(DEPTH_BYTES);

   // Byte storage; deliberately never cleared.
   logic [7:0]        mem [DEPTH_BYTES];

   logic              rdy_en_p0;
   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic              err_p1;
   logic              st_err_p1;

   logic              ld_rdy;
   logic              ld_acc;
   logic              ld_ok;
   logic              st_ok;
   logic              st_wr;
   logic [3:0]        st_nb;
   logic [DATA_W-1:0] ld_raw;

   // An access is legal when naturally aligned, fully inside storage, with
   // no address bits set above the storage index, and the size fits DATA_W.
   function automatic logic is_legal(input logic [ADDR_W-1:0] addr,
                                     input logic [1:0]        size);
      logic [3:0]  nbytes;
      logic [AW:0] end_addr;
      logic        ok;
      nbytes   = 4'd1 << size;
      end_addr = {1'b0, addr[AW-1:0]} + (AW+1)'(nbytes);
      ok       = ((addr & ADDR_W'(nbytes - 4'd1)) == '0);
      ok       = ok && ((addr >> AW) == '0);
      ok       = ok && (end_addr <= (AW+1)'(DEPTH_BYTES));
      if ((DATA_W == 32) && (size == 2'd3)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

   // Keep the low 2^size bytes and fill the rest with the sign bit of the
   // access (ld_signed) or zeros. A full-width access is passed through.
   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                                input logic [1:0]        size,
                                                input logic              sgn);
      logic [DATA_W-1:0] res;
      logic              fill;
      int                nbits;
      nbits = 8 << size;
      if (nbits > DATA_W) begin
         nbits = DATA_W;
      end
      case (size)
         2'd0:    fill = raw[7];
         2'd1:    fill = raw[15];
         2'd2:    fill = raw[31];
         default: fill = raw[DATA_W-1];
      endcase
      fill = fill & sgn;
      for (int i = 0; i < DATA_W; i++) begin
         res[i] = (i < nbits) ? raw[i] : fill;
      end
      return res;
   endfunction

   assign ld_ok  = is_legal(bus.ld_addr, bus.ld_size);
   assign st_ok  = is_legal(bus.st_addr, bus.st_size);
   assign st_nb  = 4'd1 << bus.st_size;
   assign st_wr  = bus.st_valid && st_ok;

   // The response slot is free when empty or being drained this cycle.
   assign ld_rdy = rdy_en_p0 && (!vld_p1 || bus.rsp_ready);
   assign ld_acc = bus.ld_valid && ld_rdy;

   assign bus.ld_ready  = ld_rdy;
   assign bus.rsp_valid = vld_p1;
   assign bus.rsp_data  = data_p1;
   assign bus.rsp_err   = err_p1;
   assign bus.st_err    = st_err_p1;

`ifdef DATAMEM_STORE_FWD_EN
   logic [NB-1:0] fwd_hit;
   logic [7:0]    fwd_byte [NB];
   logic [AW-1:0] fwd_rel;

   // Per load byte: does a same-cycle legal store cover it, and with which byte.
   always_comb begin
      fwd_hit = '0;
      fwd_rel = '0;
      for (int k = 0; k < NB; k++) begin
         fwd_byte[k] = '0;
         fwd_rel     = bus.ld_addr[AW-1:0] + AW'(k) - bus.st_addr[AW-1:0];
         if (st_wr && ld_ok && (fwd_rel < AW'(st_nb))) begin
            fwd_hit[k] = 1'b1;
            for (int j = 0; j < NB; j++) begin
               if (fwd_rel == AW'(j)) begin
                  fwd_byte[k] = bus.st_data[8*j +: 8];
               end
            end
         end
      end
   end
`endif

   // Gather the load bytes little-endian; illegal loads are zeroed later.
   always_comb begin
      ld_raw = '0;
      for (int k = 0; k < NB; k++) begin
         ld_raw[8*k +: 8] = mem[bus.ld_addr[AW-1:0] + AW'(k)];
`ifdef DATAMEM_STORE_FWD_EN
         if (fwd_hit[k]) begin
            ld_raw[8*k +: 8] = fwd_byte[k];
         end
`endif
      end
   end

   // ---- stage p0: ready enable comes up one cycle after reset release ----
   // Hold ld_ready low during reset and for the first cycle after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_p0 <= 1'b0;
      end else begin
         rdy_en_p0 <= 1'b1;
      end
   end

   // ---- stage p1: registered load response, held while stalled ----
   // Capture accepted loads; drain when consumed; hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         err_p1  <= 1'b0;
      end else if (ld_acc) begin
         vld_p1  <= 1'b1;
         data_p1 <= ld_ok ? extend(ld_raw, bus.ld_size, bus.ld_signed) : '0;
         err_p1  <= !ld_ok;
      end else if (bus.rsp_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   // One-cycle error pulse following an illegal store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_err_p1 <= 1'b0;
      end else begin
         st_err_p1 <= bus.st_valid && !st_ok;
      end
   end

   // Byte-wise storage write of a legal store; ignored while in reset.
   always_ff @(posedge clk) begin
      if (rst_n && st_wr) begin
         for (int k = 0; k < NB; k++) begin
            if (4'(k) < st_nb) begin
               mem[bus.st_addr[AW-1:0] + AW'(k)] <= bus.st_data[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_datamem_pipe.sv
// tb_datamem_pipe: directed scenarios plus randomized traffic for
// datamem_pipe, checked against a byte-array reference model of the memory
// and a one-entry model of the response slot.
module tb_datamem_pipe;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 1024;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   datamem_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   datamem_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_BYTES(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   byte unsigned    ref_mem [DEPTH];
   bit              exp_vld    = 1'b0;
   bit              exp_err    = 1'b0;
   bit              exp_st_err = 1'b0;
   bit              exp_rdy_en = 1'b0;
   longint unsigned exp_data   = 0;

`ifdef DATAMEM_STORE_FWD_EN
   localparam longint unsigned OVL_EXP = 64'h0000_0000_DEAD_BEEF;
`else
   localparam longint unsigned OVL_EXP = 64'h0;
`endif

   function automatic bit ref_legal(longint unsigned a, int size);
      longint unsigned n = 64'd1 << size;
      if (DATA_W == 32 && size == 3) return 1'b0;
      return ((a % n) == 0) && (a < DEPTH) && (a + n <= DEPTH);
   endfunction

   function automatic longint unsigned ref_load(longint unsigned a, int size, bit sgn);
      int n = 1 << size;
      longint unsigned val = 0;
      if (!ref_legal(a, size)) return 0;
      for (int i = 0; i < n; i++)
         val = val | (longint'(ref_mem[int'(a) + i]) << (8 * i));
      if (sgn && n < 8 && (((val >> (8 * n - 1)) & 64'd1) != 0))
         val = val | (~64'd0 << (8 * n));
      return val;
   endfunction

   task automatic ref_store(longint unsigned a, int size, longint unsigned d);
      for (int i = 0; i < (1 << size); i++)
         ref_mem[int'(a) + i] = byte'(d >> (8 * i));
   endtask

   // Advance one clock edge, updating the model from the inputs seen at it.
   task automatic tick();
      bit              acc, st_ok, ld_bad, rr;
      longint unsigned res;
      rr     = bus.rsp_ready;
      acc    = bus.ld_valid && exp_rdy_en && (!exp_vld || rr);
      st_ok  = bus.st_valid && ref_legal(bus.st_addr, int'(bus.st_size));
      ld_bad = !ref_legal(bus.ld_addr, int'(bus.ld_size));
`ifdef DATAMEM_STORE_FWD_EN
      if (st_ok) ref_store(bus.st_addr, int'(bus.st_size), bus.st_data);
`endif
      res = ref_load(bus.ld_addr, int'(bus.ld_size), bus.ld_signed);
`ifndef DATAMEM_STORE_FWD_EN
      if (st_ok) ref_store(bus.st_addr, int'(bus.st_size), bus.st_data);
`endif
      exp_st_err = bus.st_valid && !st_ok;
      @(posedge clk);
      #1;
      if (acc) begin
         exp_vld  = 1'b1;
         exp_data = res;
         exp_err  = ld_bad;
      end else if (rr) begin
         exp_vld = 1'b0;
      end
      exp_rdy_en = 1'b1;
   endtask

   task automatic idle();
      bus.ld_valid  = 1'b0;
      bus.ld_addr   = '0;
      bus.ld_size   = 2'd0;
      bus.ld_signed = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.st_valid  = 1'b0;
      bus.st_addr   = '0;
      bus.st_size   = 2'd0;
      bus.st_data   = '0;
   endtask

   task automatic set_ld(logic [63:0] a, logic [1:0] s, logic sg);
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = a;
      bus.ld_size   = s;
      bus.ld_signed = sg;
   endtask

   task automatic set_st(logic [63:0] a, logic [1:0] s, logic [63:0] d);
      bus.st_valid = 1'b1;
      bus.st_addr  = a;
      bus.st_size  = s;
      bus.st_data  = d;
   endtask

   function automatic logic [63:0] rand_addr(int sz);
      int r = $urandom_range(0, 15);
      if (r == 0) return {$urandom(), $urandom()};
      if (r == 1) return 64'($urandom_range(0, DEPTH - 1));
      return 64'($urandom_range(0, 15) << sz);
   endfunction

   task automatic test_reset();
      idle();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
      n_checks++; if (bus.rsp_data !== 64'h0) begin n_errors++; $display("FAIL rst_rsp_data got %h want 0", bus.rsp_data); end
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); end
      n_checks++; if (bus.st_err !== 1'b0) begin n_errors++; $display("FAIL rst_st_err got %b want 0", bus.st_err); end
      n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ld_ready got %b want 0", bus.ld_ready); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL rel_ld_ready_early got %b want 0", bus.ld_ready); end
      tick();
      n_checks++; if (bus.ld_ready !== 1'b1) begin n_errors++; $display("FAIL rel_ld_ready got %b want 1", bus.ld_ready); end
   endtask

   task automatic test_init();
      idle();
      for (int a = 0; a < DEPTH; a += 8) begin
         set_st(64'(a), 2'd3, 64'h0);
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_basic();
      idle();
      set_st(64'h10, 2'd3, 64'h8877665544332211);
      tick();
      idle();
      set_ld(64'h10, 2'd3, 1'b0);
      #1;
      n_checks++; if (bus.ld_ready !== 1'b1) begin n_errors++; $display("FAIL basic_ld_ready got %b want 1", bus.ld_ready); end
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL basic_rsp_valid got %b want 1", bus.rsp_valid); end
      n_checks++; if (bus.rsp_data !== 64'h8877665544332211) begin n_errors++; $display("FAIL basic_ld8 got %h want 8877665544332211", bus.rsp_data); end
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL basic_err got %b want 0", bus.rsp_err); end
      set_ld(64'h17, 2'd0, 1'b1);
      tick();
      n_checks++; if (bus.rsp_data !== 64'hFFFFFFFFFFFFFF88) begin n_errors++; $display("FAIL ld1_signed got %h want ffffffffffffff88", bus.rsp_data); end
      set_ld(64'h16, 2'd1, 1'b0);
      tick();
      n_checks++; if (bus.rsp_data !== 64'h0000000000008877) begin n_errors++; $display("FAIL ld2_unsigned got %h want 0000000000008877", bus.rsp_data); end
      idle();
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain got %b want 0", bus.rsp_valid); end
   endtask

   task automatic test_backpressure();
      idle();
      set_ld(64'h10, 2'd3, 1'b0);
      tick();
      bus.rsp_ready = 1'b0;
      set_ld(64'h08, 2'd3, 1'b0);
      set_st(64'h10, 2'd3, 64'h1122334455667788);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ld_ready cyc %0d got %b want 0", c, bus.ld_ready); end
         tick();
         bus.st_valid = 1'b0;
         n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL stall_rsp_valid cyc %0d got %b want 1", c, bus.rsp_valid); end
         n_checks++; if (bus.rsp_data !== 64'h8877665544332211) begin n_errors++; $display("FAIL stall_rsp_data cyc %0d got %h want 8877665544332211", c, bus.rsp_data); end
      end
      bus.rsp_ready = 1'b1;
      set_ld(64'h17, 2'd0, 1'b1);
      #1;
      n_checks++; if (bus.ld_ready !== 1'b1) begin n_errors++; $display("FAIL unstall_ld_ready got %b want 1", bus.ld_ready); end
      tick();
      n_checks++; if (bus.rsp_data !== 64'h11) begin n_errors++; $display("FAIL b2b_first got %h want 11", bus.rsp_data); end
      set_ld(64'h16, 2'd1, 1'b0);
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid got %b want 1", bus.rsp_valid); end
      n_checks++; if (bus.rsp_data !== 64'h1122) begin n_errors++; $display("FAIL b2b_second got %h want 1122", bus.rsp_data); end
      idle();
      tick();
   endtask

   task automatic test_illegal();
      idle();
      set_ld(64'h12, 2'd2, 1'b0);
      tick();
      n_checks++; if (bus.rsp_err !== 1'b1) begin n_errors++; $display("FAIL misalign_err got %b want 1", bus.rsp_err); end
      n_checks++; if (bus.rsp_data !== 64'h0) begin n_errors++; $display("FAIL misalign_data got %h want 0", bus.rsp_data); end
      idle();
      set_st(64'h3FC, 2'd3, 64'hFFFFFFFFFFFFFFFF);
      tick();
      n_checks++; if (bus.st_err !== 1'b1) begin n_errors++; $display("FAIL st_err_pulse got %b want 1", bus.st_err); end
      idle();
      tick();
      n_checks++; if (bus.st_err !== 1'b0) begin n_errors++; $display("FAIL st_err_clear got %b want 0", bus.st_err); end
      set_ld(64'h3FC, 2'd2, 1'b0);
      tick();
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL edge_ld_err got %b want 0", bus.rsp_err); end
      n_checks++; if (bus.rsp_data !== 64'h0) begin n_errors++; $display("FAIL edge_ld_data got %h want 0", bus.rsp_data); end
      set_ld(64'h400, 2'd0, 1'b0);
      tick();
      n_checks++; if (bus.rsp_err !== 1'b1) begin n_errors++; $display("FAIL range_err got %b want 1", bus.rsp_err); end
      set_ld(64'h8000000000000010, 2'd0, 1'b0);
      tick();
      n_checks++; if (bus.rsp_err !== 1'b1) begin n_errors++; $display("FAIL highbit_err got %b want 1", bus.rsp_err); end
      idle();
      tick();
   endtask

   task automatic test_overlap();
      idle();
      set_st(64'h20, 2'd2, 64'hDEADBEEF);
      set_ld(64'h20, 2'd3, 1'b0);
      tick();
      n_checks++; if (bus.rsp_data !== OVL_EXP) begin n_errors++; $display("FAIL overlap_data got %h want %h", bus.rsp_data, OVL_EXP); end
      idle();
      set_ld(64'h20, 2'd3, 1'b0);
      tick();
      n_checks++; if (bus.rsp_data !== 64'hDEADBEEF) begin n_errors++; $display("FAIL after_overlap got %h want deadbeef", bus.rsp_data); end
      idle();
      tick();
   endtask

   task automatic test_reset_midop();
      idle();
      set_ld(64'h10, 2'd3, 1'b0);
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_valid got %b want 1", bus.rsp_valid); end
      bus.ld_valid  = 1'b0;
      bus.rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid got %b want 0", bus.rsp_valid); end
      n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_ld_ready got %b want 0", bus.ld_ready); end
      set_st(64'h10, 2'd3, 64'hFFFFFFFFFFFFFFFF);
      @(posedge clk);
      #1;
      idle();
      rst_n      = 1'b1;
      exp_vld    = 1'b0;
      exp_rdy_en = 1'b0;
      exp_st_err = 1'b0;
      #1;
      n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_ready_early got %b want 0", bus.ld_ready); end
      set_ld(64'h10, 2'd3, 1'b0);
      tick();
      n_checks++; if (bus.ld_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_ready got %b want 1", bus.ld_ready); end
      tick();
      n_checks++; if (bus.rsp_data !== 64'h1122334455667788) begin n_errors++; $display("FAIL midrst_intact got %h want 1122334455667788", bus.rsp_data); end
      idle();
      tick();
   endtask

   task automatic test_random();
      int sz;
      bit want_rdy;
      for (int c = 0; c < 800; c++) begin
         sz             = $urandom_range(0, 3);
         bus.ld_valid   = ($urandom_range(0, 3) != 0);
         bus.ld_size    = 2'(sz);
         bus.ld_signed  = 1'($urandom_range(0, 1));
         bus.ld_addr    = rand_addr(sz);
         bus.rsp_ready  = ($urandom_range(0, 9) < 7);
         sz             = $urandom_range(0, 3);
         bus.st_valid   = ($urandom_range(0, 2) == 0);
         bus.st_size    = 2'(sz);
         bus.st_addr    = rand_addr(sz);
         bus.st_data    = {$urandom(), $urandom()};
         #1;
         want_rdy = exp_rdy_en && (!exp_vld || bus.rsp_ready);
         n_checks++; if (bus.ld_ready !== want_rdy) begin n_errors++; $display("FAIL rnd_ld_ready cyc %0d got %b want %b", c, bus.ld_ready, want_rdy); end
         tick();
         n_checks++; if (bus.rsp_valid !== exp_vld) begin n_errors++; $display("FAIL rnd_rsp_valid cyc %0d got %b want %b", c, bus.rsp_valid, exp_vld); end
         n_checks++; if (bus.st_err !== exp_st_err) begin n_errors++; $display("FAIL rnd_st_err cyc %0d got %b want %b", c, bus.st_err, exp_st_err); end
         if (exp_vld) begin
            n_checks++; if (bus.rsp_data !== exp_data) begin n_errors++; $display("FAIL rnd_rsp_data cyc %0d got %h want %h", c, bus.rsp_data, exp_data); end
            n_checks++; if (bus.rsp_err !== exp_err) begin n_errors++; $display("FAIL rnd_rsp_err cyc %0d got %b want %b", c, bus.rsp_err, exp_err); end
         end
      end
      idle();
      tick();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      test_reset();
      test_init();
      test_basic();
      test_backpressure();
      test_illegal();
      test_overlap();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
